// File: rtl/sm_controller.sv
// Instruction register, immediate sign-extension and multi-cycle control FSM
// sequencing the register file, A/B/C/status registers and ALU for MOV and ALU
// instructions.
module sm_controller #(
  parameter int unsigned IW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] ir_in,
  input  logic          load_ir,
  input  logic          s,
  output logic          w,
  output logic          illegal,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5
);

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetB,
    StGetA,
    StAlu,
    StWriteReg
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          illegal_q, illegal_d;

  // IR fields
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [1:0]    sh;
  logic [RW-1:0] rn, rd, rm;

  assign opcode = ir_q[IW-1 -: 3];
  assign op     = ir_q[IW-4 -: 2];
  assign rn     = ir_q[8 +: RW];
  assign rd     = ir_q[5 +: RW];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[0 +: RW];

  // Instruction class decode
  logic is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign sximm8  = {{(IW-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5  = {{(IW-5){ir_q[4]}}, ir_q[4:0]};
  assign illegal = illegal_q;

  // State, IR and sticky illegal flag; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StWait;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic and Moore control decode
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    w         = 1'b0;
    readnum   = '0;
    writenum  = '0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    shift     = 2'b00;
    ALUop     = 2'b00;

    unique case (state_q)
      StWait: begin
        w = 1'b1;
        // A load coinciding with start is decoded on the following cycle
        if (load_ir) ir_d = ir_in;
        if (s) state_d = StDecode;
      end
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWriteImm;
        end else if (is_mov_reg || is_alu) begin
          state_d = StGetB;
        end else begin
          illegal_d = 1'b1;
          state_d   = StWait;
        end
      end
      StWriteImm: begin
        write    = 1'b1;
        writenum = rn;
        vsel     = 2'b10;
        state_d  = StWait;
      end
      StGetB: begin
        readnum = rm;
        loadb   = 1'b1;
        // Single-operand forms skip fetching Rn
        state_d = (is_mov_reg || is_mvn) ? StAlu : StGetA;
      end
      StGetA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = StAlu;
      end
      StAlu: begin
        shift = sh;
        ALUop = is_alu ? op : 2'b00;
        // MOV reg is 0 + shifted Rm; MVN ignores A
        asel  = is_mov_reg || is_mvn;
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = StWait;
        end else begin
          loadc   = 1'b1;
          state_d = StWriteReg;
        end
      end
      StWriteReg: begin
        write    = 1'b1;
        writenum = rd;
        vsel     = 2'b00;
        state_d  = StWait;
      end
      default: state_d = StWait;
    endcase
  end

endmodule
